// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants and types for the machine-mode interrupt controller.
package interrupt_ctrl_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // mie / mip bit positions (shared layout)
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // Sleep state machine
    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } state_e;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CSR access bus between the pipeline (master) and the interrupt controller (slave).
interface interrupt_ctrl_if;
    logic        CSR_we;
    logic [11:0] CSR_addr;
    logic [31:0] CSR_wdata;
    logic [31:0] CSR_rdata;

    modport master (output CSR_we, output CSR_addr, output CSR_wdata, input CSR_rdata);
    modport slave  (input CSR_we, input CSR_addr, input CSR_wdata, output CSR_rdata);
endinterface

// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip/mtvec/mepc CSRs,
// trap entry/MRET sequencing and a WFI sleep state machine.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    AXI_Stall,
    input  logic                    Ext_Irq,
    input  logic                    Timer_Irq,
    input  logic [31:0]             ID_PC,
    input  logic                    ID_WFI,
    input  logic                    MEM_MRET,
    interrupt_ctrl_if.slave         csr_bus,
    output logic                    ID_Interrupt_Confirm,
    output logic                    ID_Interrupt_Confirm_Timer,
    output logic [31:0]             Trap_PC,
    output logic                    WFI_Stall
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic [31:0] r_mepc;
    state_e      r_state;
    state_e      w_state_next;

    logic        w_pending;
    logic        w_can_take;
    logic        w_ext_take;
    logic        w_timer_take;
    logic        w_trap;
    logic [31:0] w_mepc;
    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;

    // mepc is stored whole; the low two bits are masked on every use.
    assign w_mepc = r_mepc & 32'hFFFF_FFFC;

    // Enabled-and-pending set, independent of the global MIE bit (used for wake).
    assign w_pending = (r_mie_mtie & Timer_Irq) | (r_mie_meie & Ext_Irq);

    // Traps are only taken while running, out of reset, unstalled and not during MRET.
    assign w_can_take   = rst & (r_state == RUN) & r_mstatus_mie & ~MEM_MRET & ~AXI_Stall;
    assign w_ext_take   = w_can_take & r_mie_meie & Ext_Irq;
    assign w_timer_take = w_can_take & r_mie_mtie & Timer_Irq & ~w_ext_take;
    assign w_trap       = w_ext_take | w_timer_take;

    // Drive trap outputs and the redirect target.
    always_comb begin
        ID_Interrupt_Confirm       = w_ext_take;
        ID_Interrupt_Confirm_Timer = w_timer_take;
        Trap_PC                    = MTVEC_BASE;
        if (rst && MEM_MRET) begin
            Trap_PC = w_mepc;
        end
        WFI_Stall = rst & (r_state == SLEEP);
    end

    // Assemble CSR read values and select by address.
    always_comb begin
        w_mstatus                     = 32'h0;
        w_mstatus[MSTATUS_MIE]        = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE]       = r_mstatus_mpie;
        w_mstatus[MSTATUS_MPP_LO]     = 1'b1;
        w_mstatus[MSTATUS_MPP_LO + 1] = 1'b1;
        w_mie                         = 32'h0;
        w_mie[MIP_MTIP]               = r_mie_mtie;
        w_mie[MIP_MEIP]               = r_mie_meie;
        w_mip                         = 32'h0;
        w_mip[MIP_MTIP]               = Timer_Irq;
        w_mip[MIP_MEIP]               = Ext_Irq;
        case (csr_bus.CSR_addr)
            CSR_MSTATUS: csr_bus.CSR_rdata = w_mstatus;
            CSR_MIE:     csr_bus.CSR_rdata = w_mie;
            CSR_MIP:     csr_bus.CSR_rdata = w_mip;
            CSR_MTVEC:   csr_bus.CSR_rdata = MTVEC_BASE;
            CSR_MEPC:    csr_bus.CSR_rdata = w_mepc;
            default:     csr_bus.CSR_rdata = 32'h0;
        endcase
    end

    // CSR file: trap entry and MRET override software writes to mstatus/mepc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mepc         <= 32'h0;
        end else if (!AXI_Stall) begin
            if (csr_bus.CSR_we && csr_bus.CSR_addr == CSR_MIE) begin
                r_mie_mtie <= csr_bus.CSR_wdata[MIP_MTIP];
                r_mie_meie <= csr_bus.CSR_wdata[MIP_MEIP];
            end
            if (w_trap) begin
                r_mepc         <= ID_PC;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (MEM_MRET) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (csr_bus.CSR_we) begin
                if (csr_bus.CSR_addr == CSR_MSTATUS) begin
                    r_mstatus_mie  <= csr_bus.CSR_wdata[MSTATUS_MIE];
                    r_mstatus_mpie <= csr_bus.CSR_wdata[MSTATUS_MPIE];
                end
                if (csr_bus.CSR_addr == CSR_MEPC) begin
                    r_mepc <= csr_bus.CSR_wdata;
                end
            end
        end
    end

    // Sleep FSM state register; frozen while the bus stalls the pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
        end else if (!AXI_Stall) begin
            r_state <= w_state_next;
        end
    end

    // Sleep FSM next state: WFI sleeps only with nothing pending; any pending wakes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (ID_WFI && !w_pending) w_state_next = SLEEP;
            SLEEP:   if (w_pending)            w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed testbench for interrupt_ctrl with hand-computed expectations.
module tb_interrupt_ctrl;

    logic        clk;
    logic        rst;
    logic        AXI_Stall;
    logic        Ext_Irq;
    logic        Timer_Irq;
    logic [31:0] ID_PC;
    logic        ID_WFI;
    logic        MEM_MRET;
    logic        ID_Interrupt_Confirm;
    logic        ID_Interrupt_Confirm_Timer;
    logic [31:0] Trap_PC;
    logic        WFI_Stall;

    int checks_cnt;
    int errors_cnt;

    interrupt_ctrl_if bus();

    interrupt_ctrl #(.MTVEC_BASE(32'h0001_0000)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .AXI_Stall                  (AXI_Stall),
        .Ext_Irq                    (Ext_Irq),
        .Timer_Irq                  (Timer_Irq),
        .ID_PC                      (ID_PC),
        .ID_WFI                     (ID_WFI),
        .MEM_MRET                   (MEM_MRET),
        .csr_bus                    (bus.slave),
        .ID_Interrupt_Confirm       (ID_Interrupt_Confirm),
        .ID_Interrupt_Confirm_Timer (ID_Interrupt_Confirm_Timer),
        .Trap_PC                    (Trap_PC),
        .WFI_Stall                  (WFI_Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s 0x%08h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        bus.CSR_we    = 1'b1;
        bus.CSR_addr  = addr;
        bus.CSR_wdata = data;
        step();
        bus.CSR_we    = 1'b0;
    endtask

    task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.CSR_addr = addr;
        #1;
        check_val(tag, bus.CSR_rdata, exp);
    endtask

    task automatic do_mret();
        MEM_MRET = 1'b1;
        step();
        MEM_MRET = 1'b0;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        rst           = 1'b0;
        AXI_Stall     = 1'b0;
        Ext_Irq       = 1'b0;
        Timer_Irq     = 1'b0;
        ID_PC         = 32'h0;
        ID_WFI        = 1'b0;
        MEM_MRET      = 1'b0;
        bus.CSR_we    = 1'b0;
        bus.CSR_addr  = 12'h0;
        bus.CSR_wdata = 32'h0;

        // Reset
        step();
        step();
        check_val("rst_trap_pc", Trap_PC, 32'h0001_0000);
        check_val("rst_confirm", {30'h0, ID_Interrupt_Confirm, ID_Interrupt_Confirm_Timer}, 32'h0);
        check_val("rst_wfi_stall", {31'h0, WFI_Stall}, 32'h0);
        rst = 1'b1;
        step();
        csr_check("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_check("rst_mie", 12'h304, 32'h0);
        csr_check("rst_mepc", 12'h341, 32'h0);
        csr_check("mtvec", 12'h305, 32'h0001_0000);
        csr_write(12'h340, 32'hDEAD_BEEF);
        csr_check("unimpl_read", 12'h340, 32'h0);

        // Enable path
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        ID_PC   = 32'h120;
        Ext_Irq = 1'b1;
        #1;
        check_val("en_confirm", {31'h0, ID_Interrupt_Confirm}, 32'h1);
        check_val("en_trap_pc", Trap_PC, 32'h0001_0000);
        csr_check("mip_ext", 12'h344, 32'h800);
        step();
        check_val("en_confirm_1cyc", {31'h0, ID_Interrupt_Confirm}, 32'h0);
        Ext_Irq = 1'b0;
        csr_check("en_mepc", 12'h341, 32'h120);
        csr_check("en_mstatus", 12'h300, 32'h1880);

        // MRET
        MEM_MRET = 1'b1;
        #1;
        check_val("mret_trap_pc", Trap_PC, 32'h120);
        step();
        MEM_MRET = 1'b0;
        csr_check("mret_mstatus", 12'h300, 32'h1888);

        // Simultaneous requests: external wins
        csr_write(12'h304, 32'h880);
        ID_PC     = 32'h200;
        Ext_Irq   = 1'b1;
        Timer_Irq = 1'b1;
        #1;
        check_val("simul_ext", {31'h0, ID_Interrupt_Confirm}, 32'h1);
        check_val("simul_timer", {31'h0, ID_Interrupt_Confirm_Timer}, 32'h0);
        step();
        check_val("simul_after", {30'h0, ID_Interrupt_Confirm, ID_Interrupt_Confirm_Timer}, 32'h0);
        Ext_Irq   = 1'b0;
        Timer_Irq = 1'b0;
        csr_check("simul_mepc", 12'h341, 32'h200);
        do_mret();

        // Stall interaction
        AXI_Stall = 1'b1;
        ID_PC     = 32'h300;
        Ext_Irq   = 1'b1;
        #1;
        check_val("stall_confirm", {31'h0, ID_Interrupt_Confirm}, 32'h0);
        csr_write(12'h304, 32'h0);
        check_val("stall_confirm2", {31'h0, ID_Interrupt_Confirm}, 32'h0);
        csr_check("stall_mepc", 12'h341, 32'h200);
        csr_check("stall_mie_kept", 12'h304, 32'h880);
        AXI_Stall = 1'b0;
        #1;
        check_val("unstall_confirm", {31'h0, ID_Interrupt_Confirm}, 32'h1);
        step();
        Ext_Irq = 1'b0;
        csr_check("unstall_mepc", 12'h341, 32'h300);
        do_mret();

        // CSR write collides with trap entry: trap update wins
        csr_write(12'h341, 32'h1237);
        csr_check("mepc_mask", 12'h341, 32'h1234);
        ID_PC         = 32'h500;
        Ext_Irq       = 1'b1;
        bus.CSR_we    = 1'b1;
        bus.CSR_addr  = 12'h300;
        bus.CSR_wdata = 32'h8;
        step();
        bus.CSR_we = 1'b0;
        Ext_Irq    = 1'b0;
        csr_check("collide_mstatus", 12'h300, 32'h1880);
        csr_check("collide_mepc", 12'h341, 32'h500);
        do_mret();

        // WFI sleep and timer wake with MIE=1
        ID_WFI = 1'b1;
        #1;
        check_val("wfi_same_cycle", {31'h0, WFI_Stall}, 32'h0);
        step();
        ID_WFI = 1'b0;
        check_val("wfi_sleep", {31'h0, WFI_Stall}, 32'h1);
        step();
        ID_PC     = 32'h400;
        Timer_Irq = 1'b1;
        #1;
        check_val("sleep_no_confirm", {31'h0, ID_Interrupt_Confirm_Timer}, 32'h0);
        step();
        check_val("wake_stall", {31'h0, WFI_Stall}, 32'h0);
        check_val("wake_timer_confirm", {31'h0, ID_Interrupt_Confirm_Timer}, 32'h1);
        step();
        check_val("wake_timer_1cyc", {31'h0, ID_Interrupt_Confirm_Timer}, 32'h0);
        Timer_Irq = 1'b0;
        csr_check("wake_mepc", 12'h341, 32'h400);
        do_mret();

        // Wake with MIE=0 resumes without trap
        csr_write(12'h300, 32'h0);
        ID_WFI = 1'b1;
        step();
        ID_WFI = 1'b0;
        check_val("wfi2_sleep", {31'h0, WFI_Stall}, 32'h1);
        Ext_Irq = 1'b1;
        step();
        check_val("wfi2_wake", {31'h0, WFI_Stall}, 32'h0);
        check_val("wfi2_no_trap", {31'h0, ID_Interrupt_Confirm}, 32'h0);
        Ext_Irq = 1'b0;

        // WFI with something pending is a no-op
        Timer_Irq = 1'b1;
        ID_WFI    = 1'b1;
        step();
        ID_WFI    = 1'b0;
        Timer_Irq = 1'b0;
        check_val("wfi_noop", {31'h0, WFI_Stall}, 32'h0);

        // Reset while sleeping
        ID_WFI = 1'b1;
        step();
        ID_WFI = 1'b0;
        check_val("pre_rst_sleep", {31'h0, WFI_Stall}, 32'h1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_val("rst_sleep_stall", {31'h0, WFI_Stall}, 32'h0);
        csr_check("rst_sleep_mie", 12'h304, 32'h0);
        step();
        check_val("rst_sleep_stays_run", {31'h0, WFI_Stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
